// File: rtl/rot_share_arbiter.sv
// Round-robin arbiter sharing one left-rotate unit among NREQ requesters,
// with a one-deep registered result stage and valid/ready handshake.
module rot_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int SHW   = 2,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ*SHW-1:0]   req_shamt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [IDW-1:0]        out_id
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [IDW-1:0]     ptr_q, ptr_d;

    logic               free;
    logic               found;
    logic               xfer;
    logic [IDW-1:0]     win_id;
    logic [WIDTH-1:0]   sel_data;
    logic [SHW-1:0]     sel_shamt;
    logic [2*WIDTH-1:0] dd;
    logic [WIDTH-1:0]   rot_data;

    assign free = (state_q == EMPTY) || out_ready;

    // Scan from the round-robin pointer upward, wrapping at NREQ.
    always_comb begin
        int idx;
        found  = 1'b0;
        win_id = '0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                win_id = IDW'(idx);
            end
        end
    end

    assign req_ready = (rst_n && free && found) ?
                       (NREQ'(1) << win_id) : '0;
    assign xfer      = |(req_ready & req_valid);

    assign sel_data  = req_data[int'(win_id)*WIDTH +: WIDTH];
    assign sel_shamt = req_shamt[int'(win_id)*SHW +: SHW];

    // Left rotate: upper half of the doubled word shifted left.
    assign dd        = {sel_data, sel_data} << sel_shamt;
    assign rot_data  = dd[2*WIDTH-1 -: WIDTH];

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            EMPTY: begin
                if (xfer) state_d = FULL;
            end
            FULL: begin
                if (out_ready && !xfer) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        if (xfer) begin
            data_d = rot_data;
            id_d   = win_id;
            ptr_d  = (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_rot_share_arbiter.sv
// Directed bench for rot_share_arbiter: reset, rotate, round-robin,
// backpressure, fairness skip and drain.
module tb_rot_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_data;
    logic [7:0]  req_shamt;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_id;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_rr [4];
    logic [3:0] exp_sw [4];

    rot_share_arbiter #(
        .NREQ(4), .WIDTH(4), .SHW(2), .IDW(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shamt (req_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [3:0] d,
                           input logic [1:0] s);
        req_data[k*4 +: 4]  = d;
        req_shamt[k*2 +: 2] = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rr_data();
        set_req(0, 4'h1, 2'd1);
        set_req(1, 4'h2, 2'd1);
        set_req(2, 4'h4, 2'd1);
        set_req(3, 4'h8, 2'd1);
    endtask

    initial begin
        exp_rr[0] = 4'h2; exp_rr[1] = 4'h4;
        exp_rr[2] = 4'h8; exp_rr[3] = 4'h1;
        exp_sw[0] = 4'b1000; exp_sw[1] = 4'b0001;
        exp_sw[2] = 4'b0010; exp_sw[3] = 4'b0100;

        rst_n     = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        req_data  = '0;
        req_shamt = '0;
        rr_data();

        #12;
        check("rst_valid", 16'(out_valid), 16'h0);
        check("rst_data", 16'(out_data), 16'h0);
        check("rst_id", 16'(out_id), 16'h0);
        check("rst_ready", 16'(req_ready), 16'h0);

        tick();
        rst_n = 1'b1;
        #1;
        check("first_grant", 16'(req_ready), 16'b0001);

        for (int n = 0; n < 6; n++) begin
            tick();
            check("rr_valid", 16'(out_valid), 16'h1);
            check("rr_id", 16'(out_id), 16'(n % 4));
            check("rr_data", 16'(out_data), 16'(exp_rr[n % 4]));
            check("rr_ready", 16'(req_ready), 16'(4'b0001 << ((n + 1) % 4)));
        end

        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 16'(out_valid), 16'h0);
        check("midrst_ready", 16'(req_ready), 16'h0);
        tick();
        check("inrst_valid", 16'(out_valid), 16'h0);
        rst_n = 1'b1;
        #1;
        check("postrst_grant", 16'(req_ready), 16'b0001);
        req_valid = 4'b0000;
        tick();
        check("idle_valid", 16'(out_valid), 16'h0);

        req_valid = 4'b0010;
        set_req(1, 4'b0001, 2'd1);
        #1;
        check("single_ready", 16'(req_ready), 16'b0010);
        tick();
        check("single_data", 16'(out_data), 16'b0010);
        check("single_id", 16'(out_id), 16'h1);
        check("single_valid", 16'(out_valid), 16'h1);

        for (int s = 0; s < 4; s++) begin
            set_req(1, 4'b1000, 2'(s));
            tick();
            check("sweep_data", 16'(out_data), 16'(exp_sw[s]));
            check("sweep_id", 16'(out_id), 16'h1);
        end
        req_valid = 4'b0000;
        tick();
        check("sweep_drain", 16'(out_valid), 16'h0);

        rr_data();
        req_valid = 4'b1111;
        #1;
        check("bp_grant", 16'(req_ready), 16'b0100);
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_valid", 16'(out_valid), 16'h1);
            check("bp_id", 16'(out_id), 16'h2);
            check("bp_data", 16'(out_data), 16'h8);
            check("bp_ready", 16'(req_ready), 16'h0);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        #1;
        check("bp_resume", 16'(req_ready), 16'b1000);
        tick();
        check("bp_next_id", 16'(out_id), 16'h3);
        check("bp_next_data", 16'(out_data), 16'h1);
        req_valid = 4'b0000;
        tick();
        check("bp_drain", 16'(out_valid), 16'h0);

        req_valid = 4'b1100;
        #1;
        check("skip_g0", 16'(req_ready), 16'b0100);
        tick();
        check("skip_id0", 16'(out_id), 16'h2);
        check("skip_g1", 16'(req_ready), 16'b1000);
        tick();
        check("skip_id1", 16'(out_id), 16'h3);
        check("skip_g2", 16'(req_ready), 16'b0100);
        tick();
        check("skip_id2", 16'(out_id), 16'h2);
        out_ready = 1'b0;
        #1;
        check("wd_hold", 16'(req_ready), 16'h0);
        req_valid = 4'b0100;
        out_ready = 1'b1;
        #1;
        check("wd_grant", 16'(req_ready), 16'b0100);
        tick();
        check("wd_id", 16'(out_id), 16'h2);
        req_valid = 4'b0000;
        tick();
        check("wd_none", 16'(out_valid), 16'h0);

        req_valid = 4'b0001;
        #1;
        check("drain_grant", 16'(req_ready), 16'b0001);
        tick();
        req_valid = 4'b0000;
        check("drain_v1", 16'(out_valid), 16'h1);
        check("drain_id", 16'(out_id), 16'h0);
        check("drain_data", 16'(out_data), 16'h2);
        tick();
        check("drain_v0", 16'(out_valid), 16'h0);
        tick();
        check("drain_v0b", 16'(out_valid), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
